// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection controller: phase encoding,
// lamp codes and the default phase durations also used by the Timer block.
package traffic_pkg;

  typedef enum logic [2:0] {
    S_MAIN_G1 = 3'd0,
    S_MAIN_G2 = 3'd1,
    S_MAIN_Y  = 3'd2,
    S_WALK    = 3'd3,
    S_SIDE_G1 = 3'd4,
    S_SIDE_G2 = 3'd5,
    S_SIDE_Y  = 3'd6
  } phase_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam logic [3:0] DEF_T_BASE = 4'd6;
  localparam logic [3:0] DEF_T_EXT  = 4'd3;
  localparam logic [3:0] DEF_T_YEL  = 4'd2;

  // Any phase not owned by a street shows red, which keeps the two lights exclusive.
  function automatic logic [2:0] main_lamp(input phase_t s);
    case (s)
      S_MAIN_G1, S_MAIN_G2: return LAMP_G;
      S_MAIN_Y:             return LAMP_Y;
      default:              return LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] side_lamp(input phase_t s);
    case (s)
      S_SIDE_G1, S_SIDE_G2: return LAMP_G;
      S_SIDE_Y:             return LAMP_Y;
      default:              return LAMP_R;
    endcase
  endfunction

endpackage

// File: rtl/walk_request_latch.sv
// Remembers a pedestrian request until the walk phase is entered; a request
// arriving on the clearing edge wins so it is not lost.
module walk_request_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clear,
  output logic pending
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (set) begin
      pending <= 1'b1;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/traffic_phase_fsm.sv
// Intersection phase sequencer: steps main/walk/side phases on Timer expiry,
// loads the Timer with each phase duration and drives the registered lamps.
module traffic_phase_fsm
  import traffic_pkg::*;
#(
  parameter logic [3:0] T_BASE = DEF_T_BASE,
  parameter logic [3:0] T_EXT  = DEF_T_EXT,
  parameter logic [3:0] T_YEL  = DEF_T_YEL
) (
  input  logic       clock,
  input  logic       Reset_N,
  input  logic       Sensor,
  input  logic       Walk_Request,
  input  logic       Expired,
  output logic       Start_Timer,
  output logic [3:0] Value,
  output logic [2:0] Main_Light,
  output logic [2:0] Side_Light,
  output logic       Walk,
  output logic [2:0] State
);

  if (T_BASE == 4'd0 || T_EXT == 4'd0 || T_YEL == 4'd0) begin : g_bad_duration
    $error("traffic_phase_fsm: phase durations must be non-zero");
  end

  function automatic logic [3:0] phase_duration(input phase_t s);
    case (s)
      S_MAIN_Y, S_SIDE_Y: return T_YEL;
      S_WALK, S_SIDE_G2:  return T_EXT;
      default:            return T_BASE;
    endcase
  endfunction

  phase_t     state_q, state_d;
  logic       start_req_q;
  logic [1:0] blank_q, blank_d;
  logic       expiry_ok, advance;
  logic       walk_pending, walk_clear;
  logic       start_d, walk_d;
  logic [3:0] value_d;
  logic [2:0] main_d, side_d;

  walk_request_latch u_walk (
    .clk     (clock),
    .rst_n   (Reset_N),
    .set     (Walk_Request),
    .clear   (walk_clear),
    .pending (walk_pending)
  );

  // Blanking hides the previous interval's Expired until Timer has reloaded.
  always_comb begin
    state_d   = state_q;
    advance   = 1'b0;
    expiry_ok = Expired && (blank_q == 2'd0) && !start_req_q;
    if (expiry_ok) begin
      advance = 1'b1;
      case (state_q)
        S_MAIN_G1: state_d = Sensor ? S_MAIN_Y : S_MAIN_G2;
        S_MAIN_G2: state_d = S_MAIN_Y;
        S_MAIN_Y:  state_d = walk_pending ? S_WALK : S_SIDE_G1;
        S_WALK:    state_d = S_SIDE_G1;
        S_SIDE_G1: state_d = Sensor ? S_SIDE_G2 : S_SIDE_Y;
        S_SIDE_G2: state_d = S_SIDE_Y;
        S_SIDE_Y:  state_d = S_MAIN_G1;
        default:   state_d = S_MAIN_G1;
      endcase
    end
    walk_clear = advance && (state_d == S_WALK);
    start_d    = advance || start_req_q;
    if (start_d) begin
      blank_d = 2'd2;
      value_d = phase_duration(state_d);
    end else begin
      blank_d = (blank_q != 2'd0) ? blank_q - 2'd1 : 2'd0;
      value_d = Value;
    end
    main_d = main_lamp(state_d);
    side_d = side_lamp(state_d);
    walk_d = (state_d == S_WALK);
  end

  always_ff @(posedge clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q     <= S_MAIN_G1;
      start_req_q <= 1'b1;
      blank_q     <= 2'd0;
      Start_Timer <= 1'b0;
      Value       <= T_BASE;
      Main_Light  <= LAMP_G;
      Side_Light  <= LAMP_R;
      Walk        <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_req_q <= 1'b0;
      blank_q     <= blank_d;
      Start_Timer <= start_d;
      Value       <= value_d;
      Main_Light  <= main_d;
      Side_Light  <= side_d;
      Walk        <= walk_d;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Scoreboard bench for traffic_phase_fsm: a behavioural Timer answers each
// Start_Timer, and every pulse is matched against the expected phase queue.
module tb_traffic_phase_fsm;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, sensor, walk_req_ctl, walk_req_tm, expired;
  logic       tm_hold, walk_on_exit;
  logic       start_timer, walk;
  logic [3:0] value;
  logic [2:0] main_light, side_light, state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] st;
    logic [3:0] val;
    logic [2:0] ml;
    logic [2:0] sl;
    logic       wk;
    int         gap;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  traffic_phase_fsm dut (
    .clock        (clk),
    .Reset_N      (rst_n),
    .Sensor       (sensor),
    .Walk_Request (walk_req_ctl | walk_req_tm),
    .Expired      (expired),
    .Start_Timer  (start_timer),
    .Value        (value),
    .Main_Light   (main_light),
    .Side_Light   (side_light),
    .Walk         (walk),
    .State        (state)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected duration and lamps per phase, written out from the phase table.
  function automatic exp_t mk(input logic [2:0] st, input int gap);
    exp_t e;
    e.st = st; e.gap = gap; e.wk = 1'b0;
    case (st)
      3'd0, 3'd1: begin e.val = 4'd6; e.ml = 3'b001; e.sl = 3'b100; end
      3'd2:       begin e.val = 4'd2; e.ml = 3'b010; e.sl = 3'b100; end
      3'd3:       begin e.val = 4'd3; e.ml = 3'b100; e.sl = 3'b100; e.wk = 1'b1; end
      3'd4:       begin e.val = 4'd6; e.ml = 3'b100; e.sl = 3'b001; end
      3'd5:       begin e.val = 4'd3; e.ml = 3'b100; e.sl = 3'b001; end
      default:    begin e.val = 4'd2; e.ml = 3'b100; e.sl = 3'b010; end
    endcase
    return e;
  endfunction

  task automatic push(input logic [2:0] st, input int gap);
    sb.push_back(mk(st, gap));
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Behavioural Timer: Expired pulses value+3 cycles after each start, or is
  // held high in hold mode; optionally presses walk on the walk-phase expiry.
  initial begin
    int cnt;
    bit used;
    cnt = 0; used = 1'b0;
    expired = 1'b0; walk_req_tm = 1'b0;
    forever begin
      @(posedge clk); #1;
      expired = 1'b0;
      walk_req_tm = 1'b0;
      if (!walk_on_exit) used = 1'b0;
      if (!rst_n) cnt = 0;
      else if (start_timer) cnt = int'(value) + 3;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          expired = 1'b1;
          if (walk_on_exit && !used && state == 3'd3) begin
            walk_req_tm = 1'b1;
            used = 1'b1;
          end
        end
      end
      if (tm_hold) expired = 1'b1;
    end
  end

  initial begin
    int cyc, last;
    exp_t e;
    cyc = 0; last = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (start_timer) begin
        if (sb.size() == 0) begin
          check_eq("spurious_start", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check_eq("state", 32'(state), 32'(e.st));
          check_eq("value", 32'(value), 32'(e.val));
          check_eq("main_light", 32'(main_light), 32'(e.ml));
          check_eq("side_light", 32'(side_light), 32'(e.sl));
          check_eq("walk", 32'(walk), 32'(e.wk));
          check_eq("lamp_safe", 32'((main_light != 3'b100) && (side_light != 3'b100)), 32'd0);
          check_eq("onehot", 32'($onehot(main_light) && $onehot(side_light)), 32'd1);
          if (e.gap != 0) check_eq("phase_len", 32'(cyc - last), 32'(e.gap));
          if (e.st == 3'd3) check_eq("pending_clr", 32'(dut.walk_pending), 32'd0);
        end
        last = cyc;
      end
    end
  end

  initial begin
    rst_n = 1'b0; sensor = 1'b0; walk_req_ctl = 1'b0;
    tm_hold = 1'b0; walk_on_exit = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_main", 32'(main_light), 32'b001);
    check_eq("rst_side", 32'(side_light), 32'b100);
    check_eq("rst_walk", 32'(walk), 32'd0);
    check_eq("rst_start", 32'(start_timer), 32'd0);
    check_eq("rst_value", 32'(value), 32'd6);

    // Basic cycle with no traffic on the side street
    push(3'd0, 0); push(3'd1, 0); push(3'd2, 0);
    push(3'd4, 0); push(3'd6, 0); push(3'd0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("first_start", 32'(start_timer), 32'd1);
    check_eq("first_value", 32'(value), 32'd6);
    wait_drain(300);

    // Side-street vehicle present
    #2 sensor = 1'b1;
    push(3'd2, 0); push(3'd4, 0); push(3'd5, 0); push(3'd6, 0); push(3'd0, 0);
    wait_drain(300);

    // Single walk press, serviced once then cleared
    #2 sensor = 1'b0;
    walk_req_ctl = 1'b1;
    push(3'd1, 0); push(3'd2, 0); push(3'd3, 0); push(3'd4, 0); push(3'd6, 0); push(3'd0, 0);
    push(3'd1, 0); push(3'd2, 0); push(3'd4, 0); push(3'd6, 0); push(3'd0, 0);
    @(posedge clk); #2 walk_req_ctl = 1'b0;
    wait_drain(600);

    // Walk press on the walk-exit cycle forces a second walk phase
    #2 walk_on_exit = 1'b1;
    walk_req_ctl = 1'b1;
    push(3'd1, 0); push(3'd2, 0); push(3'd3, 0); push(3'd4, 0); push(3'd6, 0); push(3'd0, 0);
    push(3'd1, 0); push(3'd2, 0); push(3'd3, 0); push(3'd4, 0); push(3'd6, 0); push(3'd0, 0);
    @(posedge clk); #2 walk_req_ctl = 1'b0;
    wait_drain(800);
    #2 walk_on_exit = 1'b0;

    // Expired stuck high: every phase lasts three cycles
    #2 tm_hold = 1'b1;
    push(3'd1, 3); push(3'd2, 3); push(3'd4, 3); push(3'd6, 3); push(3'd0, 3);
    wait_drain(100);

    // Reset in the middle of the side extension
    #2 tm_hold = 1'b0;
    sensor = 1'b1;
    push(3'd2, 0); push(3'd4, 0); push(3'd5, 0);
    wait_drain(300);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_state", 32'(state), 32'd0);
    check_eq("arst_main", 32'(main_light), 32'b001);
    check_eq("arst_side", 32'(side_light), 32'b100);
    check_eq("arst_walk", 32'(walk), 32'd0);
    check_eq("arst_start", 32'(start_timer), 32'd0);
    check_eq("arst_value", 32'(value), 32'd6);
    check_eq("arst_pending", 32'(dut.walk_pending), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    push(3'd0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rerun_start", 32'(start_timer), 32'd1);
    wait_drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_phase_fsm.md
# traffic_phase_fsm

Phase controller for the traffic-light intersection: sequences main-street, side-street and pedestrian-walk phases and drives the lamp outputs. Sits directly upstream of `Timer`: for each phase it presents the phase duration on `Value` and pulses `Start_Timer`, then advances when `Timer` reports `Expired`. The vehicle sensor and walk button enter here; the 1 Hz enable goes only to `Timer`.

## Interface
- `T_BASE`, 4'd6: base green duration, seconds
- `T_EXT`, 4'd3: green-extension and walk duration, seconds
- `T_YEL`, 4'd2: yellow duration, seconds

- `clock`  in  1  system clock, all logic on rising edge
- `Reset_N`  in  1  asynchronous, active-low reset
- `Sensor`  in  1  side-street vehicle present, synchronous level
- `Walk_Request`  in  1  pedestrian button, synchronous, pulse or level
- `Expired`  in  1  from `Timer`, level
- `Start_Timer`  out  1  one-cycle pulse to `Timer`
- `Value`  out  4  duration for `Timer`, valid while `Start_Timer` is high and held until the next pulse
- `Main_Light`  out  3  {R,Y,G}, one-hot
- `Side_Light`  out  3  {R,Y,G}, one-hot
- `Walk`  out  1  walk lamp
- `State`  out  3  current state encoding, for debug

## Operation
- States, with their duration and lamps:
  - `S_MAIN_G1` (T_BASE): main G, side R
  - `S_MAIN_G2` (T_BASE): main G, side R
  - `S_MAIN_Y` (T_YEL): main Y, side R
  - `S_WALK` (T_EXT): both R, `Walk`=1
  - `S_SIDE_G1` (T_BASE): main R, side G
  - `S_SIDE_G2` (T_EXT): main R, side G
  - `S_SIDE_Y` (T_YEL): main R, side Y
- Transitions are taken only on a qualified expiry (see Timing):
  - `S_MAIN_G1`: to `S_MAIN_Y` if `Sensor`=1, else to `S_MAIN_G2`
  - `S_MAIN_G2` to `S_MAIN_Y`
  - `S_MAIN_Y`: to `S_WALK` if `walk_pending`, else to `S_SIDE_G1`
  - `S_WALK` to `S_SIDE_G1`
  - `S_SIDE_G1`: to `S_SIDE_G2` if `Sensor`=1, else to `S_SIDE_Y`
  - `S_SIDE_G2` to `S_SIDE_Y`
  - `S_SIDE_Y` to `S_MAIN_G1`
- `Sensor` is sampled in the cycle the expiry qualifies.
- `walk_pending`:
  - set on any cycle with `Walk_Request`=1
  - cleared on the edge that enters `S_WALK`
  - set wins over clear in the same cycle, so a request arriving during `S_WALK` is serviced on the next cycle.
- Exactly one Y/G/R bit of each light is high at all times. Main and side are never simultaneously non-red.

## Timing
- While `Reset_N`=0:
  - state `S_MAIN_G1`; `Main_Light`=3'b001, `Side_Light`=3'b100
  - `Walk`=0, `Start_Timer`=0, `Value`=T_BASE
  - `walk_pending`=0, `start_req`=1, blanking counter=0
- First rising edge after reset release: `Start_Timer`=1 for one cycle (driven by `start_req`).
- On the edge that performs a transition, state, lamps, `Value` and `Start_Timer`=1 all update together; latency from qualified expiry to new lamps is 1 cycle.
- All outputs are registered; no combinational path from inputs to outputs.
- Blanking:
  - a 2-bit counter is loaded with 2 whenever `Start_Timer` is driven high
  - `Expired` is ignored while the counter is non-zero, which masks the stale `Expired` from the previous interval
  - qualified expiry = `Expired`=1 and counter==0
- `Expired` held high past qualification does not cause a double step: the new `Start_Timer` reloads the blanking counter.
- `Reset_N` asserted mid-phase returns every register to its reset value immediately (asynchronously), regardless of state.
- Durations are 4-bit; `T_*`=0 is illegal (checked by elaboration assertion).

## Structure
- Package `traffic_pkg` holds:
  - state enum (3-bit)
  - lamp encodings `LAMP_R`=3'b100, `LAMP_Y`=3'b010, `LAMP_G`=3'b001
  - default duration constants, shared with `Timer` and the top level
- One sub-module is natural: `walk_request_latch` (set/clear flop with set priority).
- Everything else is a single FSM plus the blanking counter.

## Test plan
- Reset release with `Sensor`=0 and `Expired` pulsed after each `Start_Timer`:
  - `Start_Timer` pulses on the first edge with `Value`=6
  - sequence G1 (6), G2 (6), MAIN_Y (2), SIDE_G1 (6), SIDE_Y (2), MAIN_G1 (6)
- `Sensor`=1 throughout: MAIN_G1 goes directly to MAIN_Y; SIDE_G1 goes to SIDE_G2 with `Value`=3.
- `Walk_Request` one-cycle pulse during MAIN_G1:
  - after MAIN_Y, the FSM enters `S_WALK` with `Walk`=1, both lights R and `Value`=3
  - `walk_pending` is clear on entry
- `Walk_Request` high on the `S_WALK` exit cycle: the next MAIN_Y goes to `S_WALK` again.
- `Expired` held at 1 continuously: each state lasts exactly 3 cycles (1 transition cycle plus 2 blanked cycles), with no skipped states.
- `Reset_N` dropped mid-`S_SIDE_G2`:
  - outputs go immediately to reset values (main G, side R, `Walk`=0)
  - `Start_Timer` pulses on the first edge after release
- Integration with the real `Timer` (enable period 1000 ns, clock 200 ns): MAIN_Y lasts 2 enable periods, within ±1 clock.
